// File: rtl/enc8b10b_pkg.sv
// Shared constants and code tables for the 8b/10b encoder.
// All tables hold the RD- form; the RD+ form is the bitwise complement where one exists.
package enc8b10b_pkg;

  localparam bit RD_NEG = 1'b0;
  localparam bit RD_POS = 1'b1;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [5:0] K28_6B_NEG = 6'b001111;
  localparam logic [3:0] A7_4B_NEG  = 4'b0111;

  // 5b/6b data codes, abcdei with a as the MSB, RD- column.
  function automatic logic [5:0] enc6_neg(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
      5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;
      5'd14: return 6'b011100;  5'd15: return 6'b010111;
      5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;
      5'd20: return 6'b001011;  5'd21: return 6'b101010;
      5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;
      5'd26: return 6'b010110;  5'd27: return 6'b110110;
      5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  // 3b/4b data codes, fghj, for a negative disparity after the 6b block (primary D.x.7).
  function automatic logic [3:0] enc4_neg(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;
      3'd2: return 4'b0101;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  default: return 4'b1110;
    endcase
  endfunction

  // 3b/4b control codes for a negative disparity after the 6b block; always complemented at RD+.
  function automatic logic [3:0] k4_neg(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b0110;
      3'd2: return 4'b1010;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b0101;
      3'd6: return 4'b1001;  default: return A7_4B_NEG;
    endcase
  endfunction

  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == K23_7) || (b == K27_7) ||
           (b == K29_7) || (b == K30_7);
  endfunction

endpackage

// File: rtl/enc8b10b_if.sv
// Stream bundle between framing logic, the encoder and the serializer.
interface enc8b10b_if #(parameter int LANES = 1);
  logic [8*LANES-1:0]  datain;
  logic [LANES-1:0]    kin;
  logic                in_valid;
  logic                in_ready;
  logic [10*LANES-1:0] dataout;
  logic                out_valid;
  logic                out_ready;
  logic [LANES-1:0]    code_err;

  modport master (output datain, kin, in_valid, out_ready,
                  input  in_ready, dataout, out_valid, code_err);
  modport slave  (input  datain, kin, in_valid, out_ready,
                  output in_ready, dataout, out_valid, code_err);
endinterface

// File: rtl/enc8b10b_lane.sv
// Combinational single-byte 8b/10b encoder; rd_in/rd_out chain lanes together.
module enc8b10b_lane
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] sym10,
  output logic       rd_out,
  output logic       err
);

  logic [4:0] x;
  logic [2:0] y;
  logic       legal_k;
  logic       k28;
  logic [5:0] c6n, c6;
  logic [3:0] c4n, c4;
  logic       flip6, flip4, rd6, use_a7;

  assign x       = data[4:0];
  assign y       = data[7:5];
  assign legal_k = k && is_legal_k(data);
  assign k28     = legal_k && (x == 5'd28);

  always_comb begin
    c6n   = k28 ? K28_6B_NEG : enc6_neg(x);
    // D.7 is balanced but still has two spellings, so it flips with RD like unbalanced codes.
    flip6 = ($countones(c6n) != 3) || (x == 5'd7);
    c6    = (rd_in && flip6) ? ~c6n : c6n;
    rd6   = rd_in ^ ($countones(c6n) != 3);

    // Alternate D.x.7 avoids a run of five equal bits across the e/i-f/g boundary.
    use_a7 = (!rd6 && c6[1] && c6[0]) || (rd6 && !c6[1] && !c6[0]);
    if (legal_k)                  c4n = k4_neg(y);
    else if (y == 3'd7 && use_a7) c4n = A7_4B_NEG;
    else                          c4n = enc4_neg(y);

    flip4  = legal_k || ($countones(c4n) != 2) || (y == 3'd3);
    c4     = (rd6 && flip4) ? ~c4n : c4n;
    rd_out = rd6 ^ ($countones(c4n) != 2);
    sym10  = {c6, c4};
    err    = k && !legal_k;
  end

endmodule

// File: rtl/enc8b10b_pipe.sv
// Registered multi-lane 8b/10b encoder: lane chain, single output stage and running-disparity register.
module enc8b10b_pipe
  import enc8b10b_pkg::*;
#(
  parameter int LANES   = 1,
  parameter bit RD_INIT = RD_NEG
) (
  input  logic             clk,
  input  logic             rst,
  enc8b10b_if.slave        bus,
  input  logic             rd_load,
  input  logic             rd_value,
  output logic             RD
);

  logic [LANES:0]        rd_chain;
  logic [10*LANES-1:0]   sym;
  logic [LANES-1:0]      err;
  logic [10*LANES-1:0]   dataout_q;
  logic [LANES-1:0]      code_err_q;
  logic                  out_valid_q;
  logic                  rd_q;
  logic                  accept;

  // A same-cycle rd_load re-aligns the beat being encoded, not just the following one.
  assign rd_chain[0] = rd_load ? rd_value : rd_q;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    enc8b10b_lane u_lane (
      .data   (bus.datain[8*n +: 8]),
      .k      (bus.kin[n]),
      .rd_in  (rd_chain[n]),
      .sym10  (sym[10*n +: 10]),
      .rd_out (rd_chain[n+1]),
      .err    (err[n])
    );
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the output data register is reset too, since its reset value is observable.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataout_q   <= '0;
      code_err_q  <= '0;
      out_valid_q <= 1'b0;
      rd_q        <= RD_INIT;
    end else if (accept) begin
      dataout_q   <= sym;
      code_err_q  <= err;
      out_valid_q <= 1'b1;
      rd_q        <= rd_chain[LANES];
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (rd_load)       rd_q        <= rd_value;
    end
  end

  assign bus.dataout   = dataout_q;
  assign bus.code_err  = code_err_q;
  assign bus.out_valid = out_valid_q;
  assign RD            = rd_q;

endmodule
